// File: rtl/crc_byte_feeder.sv
// Byte feeder for the bit-serial CRC engine: FIFO, one-cycle issue pulses, frame delimiting.
// Optional frame counter output enabled by CRC_FEEDER_FRMCNT_EN.
module crc_byte_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       din,
  output logic             D_VALID,
  input  logic             D_READY,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
`ifdef CRC_FEEDER_FRMCNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } state_e;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          full, empty;
  logic          push, pop;
  logic [8:0]    head;

  state_e           state_q, state_d;
  logic [7:0]       din_q, din_d;
  logic             dv_q, dv_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             fd_q, fd_d;
  logic [LEN_W-1:0] flen_q, flen_d;

  assign full  = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (occ_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // s_ready is masked during reset so nothing is taken while RST is held
  assign s_ready = ~RST & ~full;
  assign push    = s_valid & s_ready;
  assign pop     = (state_q == IDLE) & ~empty & D_READY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {s_last, s_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    dv_d    = 1'b0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    flen_d  = flen_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          din_d   = head[7:0];
          dv_d    = 1'b1;
          last_d  = head[8];
          if (cnt_q != '1) cnt_d = cnt_q + LEN_W'(1);
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!D_READY) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        // CRC idle again: the byte is fully absorbed
        if (D_READY) begin
          if (last_q) begin
            fd_d   = 1'b1;
            flen_d = cnt_q;
            cnt_d  = '0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      din_q   <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      flen_q  <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      flen_q  <= flen_d;
    end
  end

`ifdef CRC_FEEDER_FRMCNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  assign fcnt_d = fd_d ? fcnt_q + 16'd1 : fcnt_q;

  always_ff @(posedge CLK) begin
    if (RST) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`endif

  assign din        = din_q;
  assign D_VALID    = dv_q;
  assign frame_done = fd_q;
  assign frame_len  = flen_q;
  assign busy       = ~empty | (state_q != IDLE);

endmodule
